// File: rtl/ascon_perm_iter_pkg.sv
// Shared types and constants for the iterative Ascon permutation engine.
// The 320-bit state is five 64-bit words, where element [0] is S0.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
    localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_perm_fsm;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_perm_iter_if.sv
// Control/data bundle between the mode controller (master) and the permutation engine (slave).
// start_i is a request pulse that is taken only while the engine is idle.
// done_o marks the single cycle in which state_o first shows the finished result.
interface ascon_perm_iter_if;
    import ascon_pack::*;

    logic         start_i;
    logic         p6_sel_i;
    type_state    state_i;
    logic         xor_begin_en_i;
    logic [63:0]  data_i;
    logic         xor_end_en_i;
    logic [127:0] key_i;
    type_state    state_o;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   round_o;
    type_perm_fsm fsm_o;

    modport master (
        output start_i, p6_sel_i, state_i, xor_begin_en_i, data_i, xor_end_en_i, key_i,
        input  state_o, busy_o, done_o, round_o, fsm_o
    );

    modport slave (
        input  start_i, p6_sel_i, state_i, xor_begin_en_i, data_i, xor_end_en_i, key_i,
        output state_o, busy_o, done_o, round_o, fsm_o
    );
endinterface

// File: rtl/ascon_perm_iter_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, linear diffusion.
module ascon_perm_iter_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    logic [7:0]  rc;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        rc = {4'hf - round_i, round_i};
        x0 = state_i[0];
        x1 = state_i[1];
        x2 = state_i[2] ^ {56'd0, rc};
        x3 = state_i[3];
        x4 = state_i[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        state_o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        state_o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        state_o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        state_o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon p^12 / p^6 engine: one round per clock over a registered 320-bit state,
// with optional data XOR into S0 at load and key XOR into S3/S4 after the last round.
module ascon_perm_iter
    import ascon_pack::*;
(
    input  logic clock_i,
    input  logic resetb_i,
    ascon_perm_iter_if.slave bus
);

    type_perm_fsm fsm_q, fsm_d;
    type_state    s_q, s_d, round_out;
    logic [3:0]   round_q, round_d;
    logic         xor_end_q, xor_end_d;
    logic [127:0] key_q, key_d;

    ascon_perm_iter_round u_round (
        .state_i (s_q),
        .round_i (round_q),
        .state_o (round_out)
    );

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q     <= IDLE;
            s_q       <= '0;
            round_q   <= 4'd0;
            xor_end_q <= 1'b0;
            key_q     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            s_q       <= s_d;
            round_q   <= round_d;
            xor_end_q <= xor_end_d;
            key_q     <= key_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        s_d       = s_q;
        round_d   = round_q;
        xor_end_d = xor_end_q;
        key_d     = key_q;
        case (fsm_q)
            IDLE: begin
                if (bus.start_i) begin
                    s_d = bus.state_i;
                    if (bus.xor_begin_en_i) s_d[0] = bus.state_i[0] ^ bus.data_i;
                    round_d   = bus.p6_sel_i ? ROUND_FIRST_P6 : ROUND_FIRST_P12;
                    xor_end_d = bus.xor_end_en_i;
                    key_d     = bus.key_i;
                    fsm_d     = RUN;
                end
            end
            RUN: begin
                s_d = round_out;
                // The counter holds at ROUND_LAST so it never leaves 0..11.
                if (round_q == ROUND_LAST) begin
                    if (xor_end_q) begin
                        s_d[3] = round_out[3] ^ key_q[127:64];
                        s_d[4] = round_out[4] ^ key_q[63:0];
                    end
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.state_o = s_q;
    assign bus.busy_o  = (fsm_q == RUN);
    assign bus.done_o  = (fsm_q == DONE);
    assign bus.round_o = round_q;
    assign bus.fsm_o   = fsm_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: random and directed permutations scored against
// a table-driven Ascon reference model, with a monitor checking results and round progress.
module tb_ascon_perm_iter;
    import ascon_pack::*;

    logic clk;
    logic resetb;
    int   checks;
    int   errors;
    int   exp_round;
    logic done_prev;
    logic [319:0] exp_q[$];

    ascon_perm_iter_if bus ();

    ascon_perm_iter dut (
        .clock_i  (clk),
        .resetb_i (resetb),
        .bus      (bus)
    );

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] w;
        w = {v, v} >> n;
        return w[63:0];
    endfunction

    function automatic type_state model_p(input type_state s_in, input int first);
        type_state s;
        logic [4:0] col;
        logic [4:0] o;
        s = s_in;
        for (int r = first; r <= 11; r++) begin
            s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
            for (int j = 0; j < 64; j++) begin
                col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
                o = SBOX[col];
                s[0][j] = o[4];
                s[1][j] = o[3];
                s[2][j] = o[2];
                s[3][j] = o[1];
                s[4][j] = o[0];
            end
            for (int i = 0; i < 5; i++)
                s[i] = s[i] ^ rot(s[i], ROT_A[i]) ^ rot(s[i], ROT_B[i]);
        end
        return s;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    // checking helpers
    task automatic check_val(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check_val({name, "_state"}, bus.state_o, '0);
        check_val({name, "_busy"},  320'(bus.busy_o), 320'd0);
        check_val({name, "_done"},  320'(bus.done_o), 320'd0);
        check_val({name, "_round"}, 320'(bus.round_o), 320'd0);
    endtask

    task automatic scramble_inputs();
        bus.p6_sel_i       = 1'($urandom_range(0, 1));
        bus.state_i        = rand_state();
        bus.xor_begin_en_i = 1'($urandom_range(0, 1));
        bus.data_i         = {$urandom(), $urandom()};
        bus.xor_end_en_i   = 1'($urandom_range(0, 1));
        bus.key_i          = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // driver
    task automatic launch(input type_state st, input logic p6, input logic xb, input logic [63:0] d,
                          input logic xe, input logic [127:0] k, input logic second_start);
        type_state exp_s;
        int lat;
        int busy_cnt;
        bit seen;
        exp_s = st;
        if (xb) exp_s[0] = exp_s[0] ^ d;
        exp_s = model_p(exp_s, p6 ? 6 : 0);
        if (xe) begin
            exp_s[3] = exp_s[3] ^ k[127:64];
            exp_s[4] = exp_s[4] ^ k[63:0];
        end
        exp_q.push_back(exp_s);

        @(posedge clk); #1;
        bus.start_i        = 1'b1;
        bus.p6_sel_i       = p6;
        bus.state_i        = st;
        bus.xor_begin_en_i = xb;
        bus.data_i         = d;
        bus.xor_end_en_i   = xe;
        bus.key_i          = k;
        exp_round          = p6 ? 6 : 0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        scramble_inputs();

        lat = 0;
        busy_cnt = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) seen = 1;
            if (second_start && lat == 4) begin
                bus.start_i = 1'b1;
                scramble_inputs();
            end
            if (second_start && lat == 5) bus.start_i = 1'b0;
        end
        check_val("done_latency", 320'(lat), 320'(p6 ? 7 : 13));
        check_val("busy_cycles", 320'(busy_cnt), 320'(p6 ? 6 : 12));
        @(negedge clk);
        check_val("hold_state", bus.state_o, exp_s);
        check_val("hold_done_low", 320'(bus.done_o), 320'd0);
    endtask

    task automatic abort_at_round7();
        int waited;
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.p6_sel_i = 1'b0;
        bus.state_i  = rand_state();
        exp_round    = 0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.round_o != 4'd7 && waited < 30);
        check_val("abort_reach_round7", 320'(bus.round_o), 320'd7);
        resetb = 1'b0;
        @(negedge clk);
        check_idle_zero("abort_reset");
        resetb = 1'b1;
        repeat (16) @(negedge clk);
        check_val("abort_still_idle", 320'(bus.fsm_o), 320'(IDLE));
    endtask

    // monitor / scoreboard
    initial begin
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy_o) begin
                check_val("round_seq", 320'(bus.round_o), 320'(exp_round));
                exp_round++;
            end
            if (bus.done_o === 1'b1) begin
                if (done_prev) begin
                    checks++;
                    errors++;
                    $display("FAIL done_pulse_width: got done high two cycles expected single pulse");
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with no pending result expected none");
                end else begin
                    check_val("result", bus.state_o, exp_q.pop_front());
                end
            end
            done_prev = (bus.done_o === 1'b1);
        end
    end

    // stimulus
    initial begin
        type_state kat;
        checks    = 0;
        errors    = 0;
        exp_round = 0;
        resetb    = 1'b0;
        bus.start_i = 1'b0;
        scramble_inputs();
        kat = '0;
        kat[0] = 64'h80400c0600000000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        resetb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle_zero("idle");
        end

        launch(kat, 1'b0, 1'b0, 64'd0, 1'b0, 128'd0, 1'b0);
        launch(kat, 1'b1, 1'b1, 64'h0123456789abcdef, 1'b0, 128'd0, 1'b0);
        launch(kat, 1'b0, 1'b0, 64'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        launch(kat, 1'b0, 1'b0, 64'd0, 1'b0, 128'd0, 1'b1);

        abort_at_round7();
        launch(kat, 1'b0, 1'b0, 64'd0, 1'b0, 128'd0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            launch(rand_state(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                   {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check_val("scoreboard_drained", 320'(exp_q.size()), 320'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
